alu_sched: RTL and testbench
============================

# alu_sched

Two-requester scheduler and sequencer for the shared 8-bit ALU. It arbitrates between two clients round-robin and runs each accepted 16-bit operation as two ALU passes, low byte then high byte, chaining the carry through `sc_i`/`sc_o`. It returns a 16-bit result with carry and zero flags over a backpressured response port. It sits between the decode/execute stage and the combinational ALU, and it owns all ALU operand/command inputs while instantiated.

## Interface
- No parameters. Data width is fixed at 16 bits and ALU width at 8 bits.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rq0_valid`, `rq1_valid` in 1 each: request present.
- `rq0_op`, `rq1_op` in 3 each: operation code. 000 add, 001 sub, 010 and, 011 or, 100 xor, 101–111 illegal.
- `rq0_a`, `rq0_b`, `rq1_a`, `rq1_b` in 16 each: operands.
- `rq0_ready`, `rq1_ready` out 1 each: request accepted this cycle when the matching valid is also high.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed this cycle when `rsp_valid` is also high.
- `rsp_id` out 1: requester index of the response.
- `rsp_data` out 16: result.
- `rsp_c` out 1: carry out of the high byte for add/sub; 0 for logic ops.
- `rsp_z` out 1: `rsp_data == 0`.
- `rsp_err` out 1: illegal op.
- `alu_type` out 2: tied to 00 (math group).
- `alu_m_op` out 3: ALU M_op.
- `alu_a`, `alu_b` out 8 each: ALU operands.
- `alu_sc_i` out 1: ALU carry in.
- `alu_rslt` in 8: ALU result.
- `alu_sc_o` in 1: ALU carry out.

## Operation
- The FSM has four states: IDLE, LO, HI, RESP.
- **IDLE**
  - Arbitration: if exactly one `rqN_valid` is high, it is granted.
  - If both are high, the requester other than `last_grant` is granted. `last_grant` resets to 1, so requester 0 wins the first tie.
  - `rqN_ready` is combinational, high only in IDLE and only for the granted requester.
  - On handshake, latch op, a, b and id; update `last_grant`; go to LO.
- **Operation mapping**
  - Illegal op: skip LO/HI and go straight to RESP with `rsp_data`=0, `rsp_c`=0, `rsp_z`=1, `rsp_err`=1.
  - Sub is issued to the ALU as add: operand b is bitwise-inverted and the low-byte carry in is 1. The ALU's native subtract is never used.
  - `alu_m_op` values: add/sub → 000, and → 010, or → 011, xor → 100.
- **LO**
  - Drive `alu_a`=a[7:0] and `alu_b`=b'[7:0], where b' is inverted b for sub.
  - Drive `alu_sc_i`=1 for sub, otherwise 0.
  - Latch `alu_rslt` into res[7:0] and `alu_sc_o` into the carry register. Go to HI.
- **HI**
  - Drive `alu_a`=a[15:8] and `alu_b`=b'[15:8].
  - Drive `alu_sc_i`= carry register for add/sub, 0 for logic ops.
  - Latch res[15:8] and the final carry (forced to 0 for logic ops). Go to RESP.
- **RESP**
  - `rsp_valid`=1; all response fields are stable while `rsp_valid` is high and `rsp_ready` is low.
  - On `rsp_ready`, return to IDLE. A new grant happens in the IDLE cycle that follows.
- **Outside LO/HI:** `alu_a`, `alu_b`, `alu_sc_i` and `alu_m_op` are driven to 0.
- **Carry semantics for sub:** `rsp_c`=1 means no borrow (a ≥ b, unsigned). Results wrap modulo 2^16.
- **Requester rules:** a requester must hold valid and payload until accepted. The block never drops or reorders an accepted request.

## Timing
- Legal op: handshake at cycle T, LO at T+1, HI at T+2, `rsp_valid` rises at T+3. Minimum 4 cycles per operation, including the IDLE cycle.
- Illegal op: `rsp_valid` at T+1.
- The ALU path is combinational within LO and HI; results are captured at the end of each cycle.
- Reset values:
  - state IDLE, `last_grant`=1;
  - `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_c`, `rsp_z`, `rsp_err` = 0;
  - `alu_*` outputs = 0; `rq*_ready` = 0.
- Reset asserted mid-operation (LO, HI or RESP): the operation is abandoned and no response is produced. Outputs are at reset values while `rst_n` is low.
- A valid asserted during LO/HI/RESP is not accepted until the next IDLE. `rqN_ready` stays 0 in those states.

## Test plan
- Add, requester 0: 0x00FF + 0x0001 → `rsp_data`=0x0100, c=0, z=0, id=0. `rsp_valid` rises 3 cycles after handshake.
- Sub: 0x1234 − 0x1234 → 0x0000, c=1, z=1. Then 0x0000 − 0x0001 → 0xFFFF, c=0, z=0.
- Tie: both valid continuously with ops add and xor → grants alternate 0,1,0,1 across four operations. A single requester 1 alone is granted immediately.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and all fields stay stable, and no `rq*_ready` is asserted. Releasing `rsp_ready` returns the FSM to IDLE.
- Illegal op 110 → `rsp_valid` at T+1, `rsp_err`=1, `rsp_data`=0, z=1. A following legal op then has `rsp_err`=0.
- Reset pulse in HI → all outputs return to reset values and no response appears afterward. The next request is requester 0 winning a tie.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler and sequencer for the shared 8-bit ALU.
// It accepts 16-bit operations from two requesters and runs each one as two
// ALU passes: the low byte first, then the high byte with the carry chained.
// The 16-bit result, carry, zero and error flags are returned on a response
// port with backpressure.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   rq0_*/rq1_*  valid/ready/op/a/b   requester ports (op: add,sub,and,or,xor)
//   rsp_*        valid/ready/id/data/c/z/err  response port
//   alu_*        type/m_op/a/b/sc_i (out), rslt/sc_o (in)  ALU connection
module alu_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rq0_valid,
  input  logic [2:0]  rq0_op,
  input  logic [15:0] rq0_a,
  input  logic [15:0] rq0_b,
  output logic        rq0_ready,
  input  logic        rq1_valid,
  input  logic [2:0]  rq1_op,
  input  logic [15:0] rq1_a,
  input  logic [15:0] rq1_b,
  output logic        rq1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_c,
  output logic        rsp_z,
  output logic        rsp_err,
  output logic [1:0]  alu_type,
  output logic [2:0]  alu_m_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;      // already inverted for sub
  logic        id_q, id_d;
  logic [15:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        z_q, z_d;
  logic        err_q, err_d;

  logic        gnt0, gnt1;
  logic [2:0]  gnt_op;
  logic [15:0] gnt_a, gnt_b;
  logic        is_sub, is_arith;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt0   = rq0_valid & (~rq1_valid | last_grant_q);
  assign gnt1   = rq1_valid & (~rq0_valid | ~last_grant_q);
  assign gnt_op = gnt1 ? rq1_op : rq0_op;
  assign gnt_a  = gnt1 ? rq1_a  : rq0_a;
  assign gnt_b  = gnt1 ? rq1_b  : rq0_b;

  assign is_sub   = (op_q == 3'b001);
  assign is_arith = (op_q[2:1] == 2'b00);

  assign alu_type  = 2'b00;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign rsp_c     = carry_q;
  assign rsp_z     = z_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    res_d        = res_q;
    carry_d      = carry_q;
    z_d          = z_q;
    err_d        = err_q;
    rq0_ready    = 1'b0;
    rq1_ready    = 1'b0;
    alu_m_op     = 3'b000;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_sc_i     = 1'b0;

    case (state_q)
      S_IDLE: begin
        rq0_ready = gnt0;
        rq1_ready = gnt1;
        if (gnt0 | gnt1) begin
          last_grant_d = gnt1;
          id_d         = gnt1;
          op_d         = gnt_op;
          a_d          = gnt_a;
          // Subtract runs as a + ~b + 1 on the ALU adder.
          b_d          = (gnt_op == 3'b001) ? ~gnt_b : gnt_b;
          if (gnt_op > 3'd4) begin
            res_d   = 16'h0000;
            carry_d = 1'b0;
            z_d     = 1'b1;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        // Logic op codes coincide with the ALU M_op codes.
        alu_m_op   = is_arith ? 3'b000 : op_q;
        alu_a      = a_q[7:0];
        alu_b      = b_q[7:0];
        alu_sc_i   = is_sub;
        res_d[7:0] = alu_rslt;
        carry_d    = alu_sc_o;
        state_d    = S_HI;
      end
      S_HI: begin
        alu_m_op    = is_arith ? 3'b000 : op_q;
        alu_a       = a_q[15:8];
        alu_b       = b_q[15:8];
        alu_sc_i    = is_arith & carry_q;
        res_d[15:8] = alu_rslt;
        carry_d     = is_arith & alu_sc_o;
        z_d         = ({alu_rslt, res_q[7:0]} == 16'h0000);
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      id_q         <= 1'b0;
      res_q        <= 16'h0000;
      carry_q      <= 1'b0;
      z_q          <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      z_q          <= z_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Testbench for alu_sched: behavioural 8-bit ALU, queue-driven requesters and
// a scoreboard of expected responses built from a 16-bit reference model.
`timescale 1ns/1ps
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rq0_valid = 1'b0, rq1_valid = 1'b0;
  logic [2:0]  rq0_op = '0, rq1_op = '0;
  logic [15:0] rq0_a = '0, rq0_b = '0, rq1_a = '0, rq1_b = '0;
  logic        rq0_ready, rq1_ready;
  logic        rsp_valid, rsp_id, rsp_c, rsp_z, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [1:0]  alu_type;
  logic [2:0]  alu_m_op;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sc_i, alu_sc_o;

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_valid(rq0_valid), .rq0_op(rq0_op), .rq0_a(rq0_a), .rq0_b(rq0_b), .rq0_ready(rq0_ready),
    .rq1_valid(rq1_valid), .rq1_op(rq1_op), .rq1_a(rq1_a), .rq1_b(rq1_b), .rq1_ready(rq1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .alu_type(alu_type), .alu_m_op(alu_m_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
  );

  always #5 clk = ~clk;

  // Behavioural ALU (math group).
  always_comb begin
    logic [8:0] s;
    s = 9'd0;
    alu_rslt = 8'h00;
    alu_sc_o = 1'b0;
    case (alu_m_op)
      3'b000: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_i};
        alu_rslt = s[7:0];
        alu_sc_o = s[8];
      end
      3'b001: begin
        s = {1'b0, alu_a} - {1'b0, alu_b};
        alu_rslt = s[7:0];
        alu_sc_o = ~s[8];
      end
      3'b010: alu_rslt = alu_a & alu_b;
      3'b011: alu_rslt = alu_a | alu_b;
      3'b100: alu_rslt = alu_a ^ alu_b;
      default: alu_rslt = 8'h00;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        c;
    logic        z;
    logic        err;
    int          cyc;
  } exp_t;

  req_t pend0[$];
  req_t pend1[$];
  exp_t exp_q[$];
  int   gnt_log[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit hs0_seen = 1'b0, hs1_seen = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_id = 1'b0, prev_c = 1'b0, prev_z = 1'b0, prev_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [2:0] op,
                                 input logic [15:0] a, input logic [15:0] b, input int hs);
    exp_t e;
    logic [16:0] s;
    e.id = id; e.c = 1'b0; e.err = 1'b0; e.cyc = hs + 3; e.data = 16'h0000;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[15:0]; e.c = s[16]; end
      3'd1: begin e.data = a - b; e.c = (a >= b); end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = a ^ b;
      default: begin e.err = 1'b1; e.cyc = hs + 1; end
    endcase
    e.z = (e.data == 16'h0000);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Requester drivers: present the head of each queue, retire it after a handshake.
  always @(posedge clk) begin
    #1;
    if (hs0_seen && pend0.size() > 0) void'(pend0.pop_front());
    if (hs1_seen && pend1.size() > 0) void'(pend1.pop_front());
    hs0_seen = 1'b0;
    hs1_seen = 1'b0;
    if (pend0.size() > 0) begin
      rq0_valid = 1'b1; rq0_op = pend0[0].op; rq0_a = pend0[0].a; rq0_b = pend0[0].b;
    end else rq0_valid = 1'b0;
    if (pend1.size() > 0) begin
      rq1_valid = 1'b1; rq1_op = pend1[0].op; rq1_a = pend1[0].a; rq1_b = pend1[0].b;
    end else rq1_valid = 1'b0;
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hs0_seen = 1'b0;
      hs1_seen = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      check_eq("alu_type", {30'd0, alu_type}, 32'd0);
      hs0_seen = rq0_valid && rq0_ready;
      hs1_seen = rq1_valid && rq1_ready;
      if (hs0_seen) begin
        exp_q.push_back(model(1'b0, rq0_op, rq0_a, rq0_b, cyc));
        gnt_log.push_back(0);
      end
      if (hs1_seen) begin
        exp_q.push_back(model(1'b1, rq1_op, rq1_a, rq1_b, cyc));
        gnt_log.push_back(1);
      end
      if (rsp_valid) begin
        check_eq("ready_in_resp", {30'd0, rq0_ready, rq1_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          if (!prev_valid) check_eq("latency", cyc, exp_q[0].cyc);
          else if (!prev_ready) begin
            check_eq("hold_data", rsp_data, prev_data);
            check_eq("hold_flags", {rsp_id, rsp_c, rsp_z, rsp_err},
                     {prev_id, prev_c, prev_z, prev_err});
          end
          if (rsp_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("rsp id=%0d data=0x%04h c=%0d z=%0d err=%0d (exp id=%0d data=0x%04h c=%0d z=%0d err=%0d)",
                     rsp_id, rsp_data, rsp_c, rsp_z, rsp_err, e.id, e.data, e.c, e.z, e.err);
            check_eq("rsp_id", rsp_id, e.id);
            check_eq("rsp_data", rsp_data, e.data);
            check_eq("rsp_c", rsp_c, e.c);
            check_eq("rsp_z", rsp_z, e.z);
            check_eq("rsp_err", rsp_err, e.err);
          end
        end
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready; prev_data = rsp_data;
      prev_id = rsp_id; prev_c = rsp_c; prev_z = rsp_z; prev_err = rsp_err;
    end
  end

  task automatic push_req(input int who, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (who == 0) pend0.push_back(r); else pend1.push_back(r);
  endtask

  task automatic drain(input string tag);
    int left;
    left = 200;
    while (left > 0 && (exp_q.size() + pend0.size() + pend1.size()) != 0) begin
      @(negedge clk);
      left--;
    end
    if (left == 0) check_eq({tag, "_timeout"}, exp_q.size() + pend0.size() + pend1.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_c, rsp_z, rsp_err, rsp_data}, 32'd0);
    check_eq({tag, "_alu"}, {alu_type, alu_m_op, alu_a, alu_b, alu_sc_i}, 32'd0);
    check_eq({tag, "_rdy"}, {30'd0, rq0_ready, rq1_ready}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Add with byte carry, requester 0.
    push_req(0, 3'd0, 16'h00FF, 16'h0001);
    drain("add");

    // Subtract: equal operands, then borrow.
    push_req(0, 3'd1, 16'h1234, 16'h1234);
    push_req(0, 3'd1, 16'h0000, 16'h0001);
    drain("sub");

    // Logic ops and a carry-out add.
    push_req(1, 3'd2, 16'hF0F0, 16'h3C3C);
    push_req(1, 3'd3, 16'h0F00, 16'h00F0);
    push_req(0, 3'd4, 16'hAAAA, 16'hAAAA);
    push_req(0, 3'd0, 16'hFFFF, 16'h0002);
    drain("logic");

    // Random mix across both requesters.
    for (int i = 0; i < 12; i++)
      push_req($urandom_range(0, 1), 3'($urandom_range(0, 4)), 16'($urandom), 16'($urandom));
    drain("random");

    // Illegal op followed by a legal one.
    push_req(0, 3'b110, 16'h1111, 16'h2222);
    push_req(0, 3'd0, 16'h0001, 16'h0001);
    drain("illegal");

    // Requester 1 alone is granted on the first cycle its valid is seen.
    push_req(1, 3'd0, 16'h0100, 16'h0200);
    left = 20;
    do begin
      @(negedge clk);
      left--;
    end while (!rq1_valid && left > 0);
    check_eq("solo_gnt", {31'd0, rq1_ready}, 32'd1);
    drain("solo");

    // Tie: both valid continuously, grants alternate starting with 0.
    gnt_log.delete();
    push_req(0, 3'd0, 16'h0010, 16'h0020);
    push_req(0, 3'd0, 16'h0030, 16'h0040);
    push_req(1, 3'd4, 16'h5555, 16'h0F0F);
    push_req(1, 3'd4, 16'h1234, 16'h4321);
    drain("tie");
    check_eq("tie_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < gnt_log.size(); i++)
      check_eq($sformatf("tie_gnt%0d", i), gnt_log[i], i % 2);

    // Backpressure: response held 5 cycles while another request waits.
    rsp_ready = 1'b0;
    push_req(0, 3'd1, 16'h8000, 16'h0001);
    push_req(1, 3'd3, 16'h00FF, 16'hFF00);
    left = 20;
    do begin
      @(negedge clk);
      left--;
    end while (!rsp_valid && left > 0);
    check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    rsp_ready = 1'b1;
    drain("bp");

    // Reset pulse while in HI: operation abandoned, no response afterwards.
    push_req(0, 3'd0, 16'h4321, 16'h1111);
    left = 20;
    do begin
      @(negedge clk);
      left--;
    end while (!(rq0_valid && rq0_ready) && left > 0);
    check_eq("rst_hs", {31'd0, rq0_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check_reset_outputs("rsthold");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post_rst_idle", {31'd0, rsp_valid}, 32'd0);

    // After reset requester 0 wins the first tie.
    gnt_log.delete();
    push_req(0, 3'd0, 16'h0001, 16'h0002);
    push_req(1, 3'd0, 16'h0003, 16'h0004);
    drain("rst_tie");
    check_eq("rst_tie_count", gnt_log.size(), 32'd2);
    if (gnt_log.size() == 2) begin
      check_eq("rst_tie_first", gnt_log[0], 32'd0);
      check_eq("rst_tie_second", gnt_log[1], 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
